// File: rtl/interrupt_acknowledge_master_if.sv
// Signal bundle between the interrupt acknowledge master, the PIC side and the core side.
// The master drives the strobe and vector handshake; the slave side drives everything else.
interface interrupt_acknowledge_master_if;
    logic       interrupt;
    logic       interrupt_enable;
    logic [7:0] data_bus_in;
    logic       vector_ready;
    logic       inta_n;
    logic [7:0] vector;
    logic       vector_valid;
    logic       busy;
    logic       timeout_error;

    modport master (
        input  interrupt, interrupt_enable, data_bus_in, vector_ready,
        output inta_n, vector, vector_valid, busy, timeout_error
    );

    modport slave (
        output interrupt, interrupt_enable, data_bus_in, vector_ready,
        input  inta_n, vector, vector_valid, busy, timeout_error
    );
endinterface

// File: rtl/interrupt_acknowledge_master.sv
// Two-pulse INTA sequencer: strobes the PIC, captures the vector on the second pulse,
// then offers it to the core with a bounded valid/ready handshake.
module interrupt_acknowledge_master #(
    parameter int PULSE_LOW_CYCLES = 2,
    parameter int PULSE_GAP_CYCLES = 2,
    parameter int TIMEOUT_CYCLES   = 64
) (
    input  logic                           i_clock,
    input  logic                           i_reset_n,
    interrupt_acknowledge_master_if.master ia
);

    typedef enum logic [2:0] {
        S_IDLE, S_PULSE1, S_GAP, S_PULSE2, S_HOLD, S_REARM
    } state_t;

    localparam logic [3:0] LOW_LAST = 4'(PULSE_LOW_CYCLES - 1);
    localparam logic [3:0] GAP_LAST = 4'(PULSE_GAP_CYCLES - 1);
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT_CYCLES - 1);

    state_t     r_state, w_state_nxt;
    logic [3:0] r_cnt;
    logic [7:0] r_tcnt;
    logic       r_inta_n, r_valid, r_busy, r_terr;
    logic [7:0] r_vector;
    logic       w_capture, w_timeout;

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE:   if (ia.interrupt && ia.interrupt_enable) w_state_nxt = S_PULSE1;
            S_PULSE1: if (r_cnt == LOW_LAST) w_state_nxt = S_GAP;
            S_GAP:    if (r_cnt == GAP_LAST) w_state_nxt = S_PULSE2;
            S_PULSE2: if (r_cnt == LOW_LAST) begin
                w_state_nxt = S_HOLD;
                w_capture   = 1'b1;
            end
            // Ready wins over a timeout reached on the same edge
            S_HOLD: begin
                if (ia.vector_ready) begin
                    w_state_nxt = S_REARM;
                end else if (r_tcnt == TO_LAST) begin
                    w_state_nxt = S_REARM;
                    w_timeout   = 1'b1;
                end
            end
            S_REARM:  if (r_cnt == GAP_LAST) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_tcnt   <= 8'd0;
            r_inta_n <= 1'b1;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_terr   <= 1'b0;
            r_vector <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state)  r_cnt <= 4'd0;
            else if (r_cnt != 4'hF)      r_cnt <= r_cnt + 4'd1;
            if (w_state_nxt != r_state || r_state != S_HOLD) r_tcnt <= 8'd0;
            else if (r_tcnt != 8'hFF)                        r_tcnt <= r_tcnt + 8'd1;
            r_inta_n <= !(w_state_nxt == S_PULSE1 || w_state_nxt == S_PULSE2);
            r_valid  <= (w_state_nxt == S_HOLD);
            r_busy   <= (w_state_nxt != S_IDLE);
            r_terr   <= w_timeout;
            if (w_capture) r_vector <= ia.data_bus_in;
        end
    end

    assign ia.inta_n        = r_inta_n;
    assign ia.vector        = r_vector;
    assign ia.vector_valid  = r_valid;
    assign ia.busy          = r_busy;
    assign ia.timeout_error = r_terr;

endmodule

// File: tb/tb_interrupt_acknowledge_master.sv
// Directed bench for the interrupt acknowledge master: per-cycle output traces
// for handshake, timeout, ready-at-timeout and mid-pulse reset cases.
module tb_interrupt_acknowledge_master;

    logic clk;
    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;

    interrupt_acknowledge_master_if ia ();

    interrupt_acknowledge_master #(
        .PULSE_LOW_CYCLES (2),
        .PULSE_GAP_CYCLES (2),
        .TIMEOUT_CYCLES   (4)
    ) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .ia        (ia.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Outputs are sampled 1 time unit after the edge, inputs change there too
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Thirteen cycles from the qualifying edge; bit 0 (leftmost) is the first cycle.
    // interrupt/enable are high only for the first two edges, bus switches to b2 before PULSE2.
    task automatic run_seq(input string nm, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [0:12] rdy, input logic [0:12] e_inta,
                           input logic [0:12] e_val, input logic [0:12] e_terr,
                           input logic [0:12] e_busy, input logic [7:0] e_vec);
        for (int k = 0; k < 13; k++) begin
            ia.interrupt        = (k < 2);
            ia.interrupt_enable = (k < 2);
            ia.data_bus_in      = (k >= 4) ? b2 : b1;
            ia.vector_ready     = rdy[k];
            tick();
            chk($sformatf("%s inta_n t%0d", nm, k + 1), 32'(ia.inta_n), 32'(e_inta[k]));
            chk($sformatf("%s valid t%0d", nm, k + 1), 32'(ia.vector_valid), 32'(e_val[k]));
            chk($sformatf("%s terr t%0d", nm, k + 1), 32'(ia.timeout_error), 32'(e_terr[k]));
            chk($sformatf("%s busy t%0d", nm, k + 1), 32'(ia.busy), 32'(e_busy[k]));
        end
        chk($sformatf("%s vector", nm), 32'(ia.vector), 32'(e_vec));
        ia.vector_ready = 1'b0;
    endtask

    initial begin
        rst_n               = 1'b0;
        ia.interrupt        = 1'b0;
        ia.interrupt_enable = 1'b0;
        ia.data_bus_in      = 8'h00;
        ia.vector_ready     = 1'b0;
        tick();
        tick();
        chk("rst inta_n", 32'(ia.inta_n), 32'd1);
        chk("rst vector", 32'(ia.vector), 32'h00);
        chk("rst valid",  32'(ia.vector_valid), 32'd0);
        chk("rst busy",   32'(ia.busy), 32'd0);
        chk("rst terr",   32'(ia.timeout_error), 32'd0);
        rst_n = 1'b1;
        tick();

        // Ready tied high: low 2, high 2, low 2, one valid cycle, REARM 2 cycles
        run_seq("basic", 8'hAA, 8'h48, 13'b1111111111111,
                13'b0011001111111, 13'b0000001000000,
                13'b0000000000000, 13'b1111111110000, 8'h48);

        // Disabled interrupts must not start a sequence
        ia.interrupt        = 1'b1;
        ia.interrupt_enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("blocked inta_n c%0d", i), 32'(ia.inta_n), 32'd1);
            chk($sformatf("blocked busy c%0d", i), 32'(ia.busy), 32'd0);
        end

        // Enable then drop interrupt mid-PULSE1, PULSE1 bus ignored, no ready -> timeout
        run_seq("timeout", 8'h55, 8'h0F, 13'b0000000000000,
                13'b0011001111111, 13'b0000001111000,
                13'b0000000000100, 13'b1111111111110, 8'h0F);

        // Ready arriving on the timeout edge wins
        run_seq("coincide", 8'h11, 8'h33, 13'b0000000000100,
                13'b0011001111111, 13'b0000001111000,
                13'b0000000000000, 13'b1111111111110, 8'h33);

        // Reset during PULSE2 discards the sequence
        ia.interrupt        = 1'b1;
        ia.interrupt_enable = 1'b1;
        ia.data_bus_in      = 8'h77;
        for (int i = 0; i < 5; i++) tick();
        chk("pre-rst inta_n", 32'(ia.inta_n), 32'd0);
        rst_n = 1'b0;
        tick();
        chk("midrst inta_n", 32'(ia.inta_n), 32'd1);
        chk("midrst vector", 32'(ia.vector), 32'h00);
        chk("midrst busy",   32'(ia.busy), 32'd0);
        chk("midrst valid",  32'(ia.vector_valid), 32'd0);
        rst_n        = 1'b1;
        ia.interrupt = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("post-rst inta_n c%0d", i), 32'(ia.inta_n), 32'd1);
            chk($sformatf("post-rst valid c%0d", i), 32'(ia.vector_valid), 32'd0);
            chk($sformatf("post-rst busy c%0d", i), 32'(ia.busy), 32'd0);
        end
        chk("post-rst vector", 32'(ia.vector), 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/interrupt_acknowledge_master.md
INTERRUPT_ACKNOWLEDGE_MASTER -- requirements
Module: interrupt_acknowledge_master

Interface
REQ-001 Parameter PULSE_LOW_CYCLES, default 2: cycles inta_n is held low per acknowledge pulse; legal range 1..15.
REQ-002 Parameter PULSE_GAP_CYCLES, default 2: cycles inta_n is held high between the two pulses and after handshake; legal range 1..15.
REQ-003 Parameter TIMEOUT_CYCLES, default 64: cycles vector_valid waits for vector_ready before abandoning; legal range 1..255.
REQ-004 clock  input  1  single system clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset; sampled on the rising clock edge.
REQ-006 interrupt  input  1  INT level from the PIC, synchronous to clock.
REQ-007 interrupt_enable  input  1  CPU interrupt-enable flag; 0 blocks new acknowledge cycles.
REQ-008 data_bus_in  input  8  PIC data bus, carrying the vector during the second pulse.
REQ-009 vector_ready  input  1  core accepts the vector.
REQ-010 inta_n  output  1  active-low interrupt acknowledge strobe to the PIC.
REQ-011 vector  output  8  captured interrupt vector.
REQ-012 vector_valid  output  1  vector is held stable and offered to the core.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 timeout_error  output  1  one-cycle pulse when an offered vector is abandoned.

Function
REQ-015 FSM states SHALL be IDLE, PULSE1, GAP, PULSE2, HOLD, REARM; all outputs SHALL be registered.
REQ-016 IDLE -> PULSE1 SHALL occur on an edge where interrupt=1 and interrupt_enable=1; otherwise the FSM SHALL stay in IDLE.
REQ-017 inta_n SHALL go low in the first cycle of PULSE1 (one cycle after the qualifying sample) and stay low for exactly PULSE_LOW_CYCLES cycles.
REQ-018 GAP SHALL hold inta_n high for exactly PULSE_GAP_CYCLES cycles, then enter PULSE2.
REQ-019 PULSE2 SHALL hold inta_n low for exactly PULSE_LOW_CYCLES cycles; data_bus_in SHALL be captured into vector on the edge that ends the last low cycle.
REQ-020 Once PULSE1 is entered, the two-pulse sequence SHALL complete regardless of interrupt or interrupt_enable changes; data_bus_in during PULSE1 SHALL be ignored.
REQ-021 HOLD SHALL start the cycle after PULSE2, with inta_n=1, vector_valid=1 and vector stable.
REQ-022 In HOLD, vector_ready=1 on an edge SHALL complete the handshake: vector_valid drops the next cycle, FSM enters REARM.
REQ-023 vector_ready while not in HOLD SHALL be ignored.
REQ-024 A HOLD wait counter SHALL count cycles with vector_valid=1 and vector_ready=0; after TIMEOUT_CYCLES such cycles, vector_valid SHALL drop, timeout_error SHALL pulse for one cycle, and FSM SHALL enter REARM.
REQ-025 If vector_ready=1 on the same edge the timeout is reached, the handshake SHALL win and timeout_error SHALL stay 0.
REQ-026 REARM SHALL last exactly PULSE_GAP_CYCLES cycles with inta_n=1, then return to IDLE; interrupt is not sampled in REARM.
REQ-027 vector SHALL retain its last captured value until the next PULSE2 capture.
REQ-028 All cycle counters SHALL be 4 bits, except the timeout counter (8 bits); they SHALL clear on every state entry and never wrap.

Reset
REQ-029 reset_n=0 on an edge SHALL force IDLE, inta_n=1, vector=8'h00, vector_valid=0, busy=0, timeout_error=0, and all counters to 0.
REQ-030 Reset asserted mid-pulse SHALL release inta_n high in the next cycle and discard any partial capture.
REQ-031 After reset_n returns to 1, a new sequence SHALL require a fresh qualifying sample in IDLE.

Verification
REQ-032 Defaults, interrupt=1, enable=1, bus=8'h48 in PULSE2, ready tied 1 -> inta_n low 2 cycles, high 2, low 2; vector=8'h48; vector_valid high exactly 1 cycle; busy through REARM.
REQ-033 interrupt=1, enable=0 for 20 cycles -> inta_n stays 1, busy=0; enable=1 -> PULSE1 starts the next cycle.
REQ-034 interrupt drops after the first PULSE1 cycle, bus=8'h0F in PULSE2 -> second pulse still issued, vector=8'h0F.
REQ-035 TIMEOUT_CYCLES=4, ready=0 -> vector_valid high 4 cycles, timeout_error single pulse, then REARM then IDLE.
REQ-036 ready=1 coinciding with the timeout edge -> handshake completes, timeout_error=0.
REQ-037 reset_n=0 during PULSE2 -> next cycle inta_n=1, vector=8'h00, state IDLE; no vector_valid.
